// File: rtl/reg_bank_burst_if.sv
// Bus bundle for reg_bank_burst: direct write, random read, burst command,
// burst write stream and burst read stream.
interface reg_bank_burst_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_W-1:0]     rd_data;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [ADDR_W-1:0]     cmd_len;
  logic                  bw_valid;
  logic                  bw_ready;
  logic [DATA_W-1:0]     bw_data;
  logic                  br_valid;
  logic                  br_ready;
  logic [DATA_W-1:0]     br_data;
  logic                  br_last;
  logic                  busy;

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_addr,
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  bw_valid, bw_data, br_ready,
    output rd_data, cmd_ready, bw_ready, br_valid, br_data, br_last, busy
  );

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_addr,
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output bw_valid, bw_data, br_ready,
    input  rd_data, cmd_ready, bw_ready, br_valid, br_data, br_last, busy
  );
endinterface

// File: rtl/reg_bank_burst.sv
// Register bank with byte-enabled direct writes, combinational random read and an
// auto-incrementing burst engine streaming words in or out over valid/ready.
module reg_bank_burst #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input logic             clk,
  input logic             reset,
  reg_bank_burst_if.slave bus
);
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned NBYTES = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                more_q, more_d;  // words still to be loaded in a read burst
  logic                br_valid_q, br_valid_d;
  logic                br_last_q, br_last_d;
  logic [DATA_W-1:0]   br_data_q, br_data_d;
  logic                bw_fire;
  logic                load;
  logic                cmd_ready;
  logic                bw_ready;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    more_d     = more_q;
    br_valid_d = br_valid_q;
    br_last_d  = br_last_q;
    br_data_d  = br_data_q;
    bw_fire    = 1'b0;
    load       = 1'b0;
    cmd_ready  = 1'b0;
    bw_ready   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          ptr_d   = bus.cmd_addr;
          cnt_d   = bus.cmd_len;
          more_d  = 1'b1;
          state_d = bus.cmd_write ? StWrite : StRead;
        end
      end
      StWrite: begin
        // Direct write owns the array port this cycle.
        bw_ready = !bus.wr_en;
        if (bus.bw_valid && bw_ready) begin
          bw_fire = 1'b1;
          ptr_d   = ptr_q + ADDR_W'(1);
          if (cnt_q == '0) begin
            more_d  = 1'b0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - ADDR_W'(1);
          end
        end
      end
      StRead: begin
        load = more_q && (!br_valid_q || bus.br_ready);
        if (load) begin
          br_data_d  = mem_q[ptr_q];
          br_last_d  = (cnt_q == '0);
          br_valid_d = 1'b1;
          ptr_d      = ptr_q + ADDR_W'(1);
          if (cnt_q == '0) begin
            more_d = 1'b0;
          end else begin
            cnt_d = cnt_q - ADDR_W'(1);
          end
        end else if (br_valid_q && bus.br_ready) begin
          // With nothing left to load, the word just taken was the last one.
          br_valid_d = 1'b0;
          br_last_d  = 1'b0;
          if (br_last_q) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      cnt_q      <= '0;
      more_q     <= 1'b0;
      br_valid_q <= 1'b0;
      br_last_q  <= 1'b0;
      br_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      more_q     <= more_d;
      br_valid_q <= br_valid_d;
      br_last_q  <= br_last_d;
      br_data_q  <= br_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (bus.wr_en) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (bus.wr_be[b]) begin
          mem_q[bus.wr_addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
        end
      end
    end else if (bw_fire) begin
      mem_q[ptr_q] <= bus.bw_data;
    end
  end

  assign bus.rd_data   = mem_q[bus.rd_addr];
  assign bus.cmd_ready = cmd_ready;
  assign bus.bw_ready  = bw_ready;
  assign bus.br_valid  = br_valid_q;
  assign bus.br_data   = br_data_q;
  assign bus.br_last   = br_last_q;
  assign bus.busy      = (state_q != StIdle);
endmodule
